cordic_output_stage: RTL

- Sits directly downstream of the CORDIC iteration pipeline and consumes its valid + {func, X, Y, Z} output at operand width.
- Performs three jobs:
  - CORDIC gain compensation on X and Y by multiplying with K ≈ 0.60725.
  - Round and saturate all three operands back to DATA_WIDTH.
  - Buffer results in a FIFO with a valid/ready output handshake.
- The iteration pipeline cannot stall, so this block drives a conservative throttle signal back to the feeder to prevent loss.

---
 rtl/cordic_output_stage.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cordic_output_stage.sv
// rtl/cordic_output_stage.sv - CORDIC gain compensation, round/saturate and output FIFO
module cordic_output_stage #(
    parameter int FUNC_WIDTH    = 1,
    parameter int DATA_WIDTH    = 16,
    parameter int DATA_OP_WIDTH = 18,
    parameter int NUM_DATA      = 3,
    parameter int EN_SCALE      = 1,
    parameter int K_Q15         = 19898,
    parameter int UP_LAT        = 2,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_vld,
    input  logic [FUNC_WIDTH+NUM_DATA*DATA_OP_WIDTH-1:0] i_data,
    output logic                                   o_in_rdy,
    output logic                                   o_vld,
    input  logic                                   i_rdy,
    output logic [FUNC_WIDTH+NUM_DATA*DATA_WIDTH-1:0] o_data,
    output logic                                   o_ovf,
    output logic [$clog2(FIFO_DEPTH):0]            o_count
);
    localparam int OUT_W = FUNC_WIDTH + NUM_DATA * DATA_WIDTH;
    localparam int PW    = DATA_OP_WIDTH + 17;
    localparam int RW    = PW + 1;
    localparam int QW    = RW - 15;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int SW    = CW + 2;
    // Unscaled build multiplies by 1.0 in Q1.15, which is exactly X<<15.
    localparam logic signed [16:0] K_S = 17'((EN_SCALE != 0) ? K_Q15 : 32768);
    localparam logic signed [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [FUNC_WIDTH-1:0]           in_func;
    logic signed [DATA_OP_WIDTH-1:0] in_x, in_y, in_z;

    assign in_func = i_data[FUNC_WIDTH+NUM_DATA*DATA_OP_WIDTH-1 -: FUNC_WIDTH];
    assign in_x    = i_data[2*DATA_OP_WIDTH +: DATA_OP_WIDTH];
    assign in_y    = i_data[DATA_OP_WIDTH +: DATA_OP_WIDTH];
    assign in_z    = i_data[0 +: DATA_OP_WIDTH];

    // Round half-up then clamp a scaled product to the output range.
    function automatic logic signed [DATA_WIDTH-1:0] rnd_sat(input logic signed [PW-1:0] p);
        logic signed [QW-1:0] q;
        q = QW'((RW'(p) + RW'(16384)) >>> 15);
        if (q[QW-1:DATA_WIDTH-1] == {(QW-DATA_WIDTH+1){q[QW-1]}})
            return q[DATA_WIDTH-1:0];
        else
            return q[QW-1] ? S_MIN : S_MAX;
    endfunction

    // Clamp an unscaled operand to the output range.
    function automatic logic signed [DATA_WIDTH-1:0] sat_z(input logic signed [DATA_OP_WIDTH-1:0] z);
        if (z[DATA_OP_WIDTH-1:DATA_WIDTH-1] == {(DATA_OP_WIDTH-DATA_WIDTH+1){z[DATA_OP_WIDTH-1]}})
            return z[DATA_WIDTH-1:0];
        else
            return z[DATA_OP_WIDTH-1] ? S_MIN : S_MAX;
    endfunction

    logic                            s1_vld;
    logic [FUNC_WIDTH-1:0]           s1_func;
    logic signed [DATA_OP_WIDTH-1:0] s1_z;
    logic signed [PW-1:0]            s1_px, s1_py;

    // Stage 1: gain multiply, carry tag and Z alongside.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_vld  <= 1'b0;
            s1_func <= '0;
            s1_z    <= '0;
            s1_px   <= '0;
            s1_py   <= '0;
        end else begin
            s1_vld  <= i_vld;
            s1_func <= in_func;
            s1_z    <= in_z;
            s1_px   <= PW'(in_x) * PW'(K_S);
            s1_py   <= PW'(in_y) * PW'(K_S);
        end
    end

    logic                         s2_vld;
    logic [FUNC_WIDTH-1:0]        s2_func;
    logic signed [DATA_WIDTH-1:0] s2_x, s2_y, s2_z;

    // Stage 2: round and saturate back to output width.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_vld  <= 1'b0;
            s2_func <= '0;
            s2_x    <= '0;
            s2_y    <= '0;
            s2_z    <= '0;
        end else begin
            s2_vld  <= s1_vld;
            s2_func <= s1_func;
            s2_x    <= rnd_sat(s1_px);
            s2_y    <= rnd_sat(s1_py);
            s2_z    <= sat_z(s1_z);
        end
    end

    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             full, pop, wr_en, drop;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign o_vld = (count != '0);
    assign pop   = o_vld && i_rdy;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign wr_en = s2_vld && (!full || pop);
    assign drop  = s2_vld && full && !pop;

    // FIFO storage; head is read straight from the array.
    always_ff @(posedge i_clk) begin
        if (wr_en)
            mem[wr_ptr] <= {s2_func, s2_x, s2_y, s2_z};
    end

    // FIFO pointers, occupancy and sticky drop flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            o_ovf  <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop)
                count <= count + 1'b1;
            else if (!wr_en && pop)
                count <= count - 1'b1;
            if (drop)
                o_ovf <= 1'b1;
        end
    end

    assign o_data  = o_vld ? mem[rd_ptr] : '0;
    assign o_count = count;

    // Reserve room for everything already in flight, upstream and here.
    assign o_in_rdy = (SW'(count) + SW'(s1_vld) + SW'(s2_vld) + SW'(UP_LAT + 1)) < SW'(FIFO_DEPTH);

endmodule
